// File: rtl/ipg_tx_inject.sv
// ipg_tx_inject: inter-packet-gap message injector for the 10G BASE-R TX path.
// Buffers 64-bit reply chunks in a small FIFO and substitutes one chunk into each
// idle control block of the encoded stream. All other blocks pass through unchanged
// with a fixed one-cycle latency.
// Optional feature: define IPG_TX_STATS_EN to add the ipg_insert_count output.

module ipg_tx_inject #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned HDR_WIDTH      = 2,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned PAUSE_THRESH   = 12,
    parameter logic [7:0]  IPG_BLOCK_TYPE = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    input  logic                  netq_write,
    input  logic                  memq_write,
    input  logic [DATA_WIDTH-1:0] ipg_reply_chunk,
    output logic [DATA_WIDTH-1:0] proced_encoded_tx_data,
    output logic [HDR_WIDTH-1:0]  proced_encoded_tx_hdr,
    output logic                  tx_pause,
    output logic                  memq_overflow
`ifdef IPG_TX_STATS_EN
    ,
    output logic [31:0]           ipg_insert_count
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    // Only the upper bytes of a chunk carry payload; the low byte becomes the type.
    localparam int unsigned PLD_W = DATA_WIDTH - 8;

    localparam logic [HDR_WIDTH-1:0]  HDR_CTRL   = 2'b10;
    localparam logic [7:0]            TYPE_IDLE  = 8'h1E;
    localparam logic [DATA_WIDTH-1:0] IDLE_BLOCK = {{PLD_W{1'b0}}, TYPE_IDLE};

    // Elaboration-time parameter legality checks.
    if (DATA_WIDTH != 64) begin : g_bad_data_width
        $error("ipg_tx_inject: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hdr_width
        $error("ipg_tx_inject: HDR_WIDTH must be 2");
    end
    if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("ipg_tx_inject: FIFO_DEPTH must be a power of two >= 4");
    end
    if ((PAUSE_THRESH < 1) || (PAUSE_THRESH > FIFO_DEPTH)) begin : g_bad_thresh
        $error("ipg_tx_inject: PAUSE_THRESH must be in 1..FIFO_DEPTH");
    end

    // FIFO storage and state
    logic [PLD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    // Registered output block
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [HDR_WIDTH-1:0]  r_out_hdr;

    logic             w_empty;
    logic             w_full;
    logic             w_idle;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [PLD_W-1:0] w_head;
    logic             w_unused_rsvd;

    // Reserved low byte of a reply chunk is never stored.
    assign w_unused_rsvd = ^ipg_reply_chunk[7:0];

    // FIFO flags and the injection decision
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CNT_W'(FIFO_DEPTH));
        w_idle  = (encoded_tx_hdr == HDR_CTRL) && (encoded_tx_data == IDLE_BLOCK);
        // Empty is judged on the registered count, so a chunk written this cycle
        // cannot be popped until the next one.
        w_pop   = !netq_write && w_idle && !w_empty;
        // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
        w_push  = memq_write && (!w_full || w_pop);
        w_drop  = memq_write && w_full && !w_pop;
        w_head  = r_mem[r_rd_ptr];
    end

    // FIFO storage write; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ipg_reply_chunk[DATA_WIDTH-1:8];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // One-cycle output stage: either the input block or the injected chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_hdr  <= HDR_CTRL;
            r_out_data <= IDLE_BLOCK;
        end else if (w_pop) begin
            r_out_hdr  <= HDR_CTRL;
            r_out_data <= {w_head, IPG_BLOCK_TYPE};
        end else begin
            r_out_hdr  <= encoded_tx_hdr;
            r_out_data <= encoded_tx_data;
        end
    end

`ifdef IPG_TX_STATS_EN
    logic [31:0] r_insert_count;

    // Count injected blocks; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_insert_count <= '0;
        end else if (w_pop) begin
            r_insert_count <= r_insert_count + 32'd1;
        end
    end

    assign ipg_insert_count = r_insert_count;
`endif

    assign proced_encoded_tx_data = r_out_data;
    assign proced_encoded_tx_hdr  = r_out_hdr;
    assign tx_pause               = (r_count >= CNT_W'(PAUSE_THRESH));
    assign memq_overflow          = r_overflow;

endmodule

// File: tb/tb_ipg_tx_inject.sv
// Self-checking bench for ipg_tx_inject: directed scenarios plus a randomized run,
// all checked against a queue-based reference model.

module tb_ipg_tx_inject;

    logic        clk;
    logic        rst_n;
    logic [63:0] encoded_tx_data;
    logic [1:0]  encoded_tx_hdr;
    logic        netq_write;
    logic        memq_write;
    logic [63:0] ipg_reply_chunk;
    logic [63:0] proced_encoded_tx_data;
    logic [1:0]  proced_encoded_tx_hdr;
    logic        tx_pause;
    logic        memq_overflow;
`ifdef IPG_TX_STATS_EN
    logic [31:0] ipg_insert_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0] m_q[$];
    logic        m_ovf;
    int unsigned m_inserts;

    // Expected outputs after the most recent step
    logic [1:0]  exp_hdr;
    logic [63:0] exp_data;
    logic        exp_pause;
    logic        exp_ovf;

    ipg_tx_inject #(
        .DATA_WIDTH    (64),
        .HDR_WIDTH     (2),
        .FIFO_DEPTH    (16),
        .PAUSE_THRESH  (12),
        .IPG_BLOCK_TYPE(8'h00)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .encoded_tx_data       (encoded_tx_data),
        .encoded_tx_hdr        (encoded_tx_hdr),
        .netq_write            (netq_write),
        .memq_write            (memq_write),
        .ipg_reply_chunk       (ipg_reply_chunk),
        .proced_encoded_tx_data(proced_encoded_tx_data),
        .proced_encoded_tx_hdr (proced_encoded_tx_hdr),
        .tx_pause              (tx_pause),
        .memq_overflow         (memq_overflow)
`ifdef IPG_TX_STATS_EN
        ,
        .ipg_insert_count      (ipg_insert_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] hdr, input logic [63:0] data, input logic netq,
                         input logic wr, input logic [63:0] chunk);
        encoded_tx_hdr  = hdr;
        encoded_tx_data = data;
        netq_write      = netq;
        memq_write      = wr;
        ipg_reply_chunk = chunk;
    endtask

    task automatic drive_idle(input logic wr, input logic [63:0] chunk);
        drive(2'b10, 64'h1E, 1'b0, wr, chunk);
    endtask

    function automatic logic [63:0] rand_chunk();
        return {$urandom, $urandom_range(32'hFFFF_FFFF, 0) & 32'hFFFF_FF00};
    endfunction

    // Advance one clock: model consumes current inputs, then outputs are sampled at +1.
    task automatic step();
        logic idle;
        logic inj;
        idle = (encoded_tx_hdr == 2'b10) && (encoded_tx_data == 64'h1E);
        inj  = !netq_write && idle && (m_q.size() > 0);
        if (inj) begin
            exp_hdr  = 2'b10;
            exp_data = {m_q[0][63:8], 8'h00};
            void'(m_q.pop_front());
            m_inserts++;
        end else begin
            exp_hdr  = encoded_tx_hdr;
            exp_data = encoded_tx_data;
        end
        if (memq_write) begin
            if (m_q.size() < 16) m_q.push_back(ipg_reply_chunk);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        exp_pause = (m_q.size() >= 12);
        exp_ovf   = m_ovf;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        m_q.delete();
        m_ovf     = 1'b0;
        m_inserts = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle(1'b0, 64'h0);
        rst_n = 1'b0;
        m_q.delete();
        m_ovf     = 1'b0;
        m_inserts = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (proced_encoded_tx_hdr !== 2'b10 || proced_encoded_tx_data !== 64'h1E) begin
            errors++;
            $display("FAIL reset_block got %h/%h want 2/000000000000001e",
                     proced_encoded_tx_hdr, proced_encoded_tx_data);
        end
        checks++;
        if (tx_pause !== 1'b0 || memq_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got pause=%b ovf=%b want 0 0", tx_pause, memq_overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 3; i++) begin
            drive_idle(1'b0, 64'h0);
            step();
            checks++;
            if (proced_encoded_tx_hdr !== 2'b10 || proced_encoded_tx_data !== 64'h1E) begin
                errors++;
                $display("FAIL pass_idle got %h/%h want 2/1e", proced_encoded_tx_hdr,
                         proced_encoded_tx_data);
            end
        end
        drive(2'b01, 64'hDEADBEEF_01234567, 1'b1, 1'b0, 64'h0);
        step();
        checks++;
        if (proced_encoded_tx_hdr !== 2'b01 || proced_encoded_tx_data !== 64'hDEADBEEF_01234567)
        begin
            errors++;
            $display("FAIL pass_frame got %h/%h want 1/deadbeef01234567",
                     proced_encoded_tx_hdr, proced_encoded_tx_data);
        end
    endtask

    task automatic test_injection();
        drive(2'b01, 64'h55, 1'b1, 1'b1, 64'h1122334455667700);
        step();
        drive_idle(1'b0, 64'h0);
        step();
        checks++;
        if (proced_encoded_tx_hdr !== 2'b10 || proced_encoded_tx_data !== 64'h1122334455667700)
        begin
            errors++;
            $display("FAIL inject got %h/%h want 2/1122334455667700",
                     proced_encoded_tx_hdr, proced_encoded_tx_data);
        end
        // FIFO now empty: the next idle passes through untouched
        step();
        checks++;
        if (proced_encoded_tx_data !== 64'h1E) begin
            errors++;
            $display("FAIL inject_empty got %h want 1e", proced_encoded_tx_data);
        end
    endtask

    task automatic test_no_inject_frames();
        logic [63:0] ch [3];
        logic [1:0]  fh [3];
        logic [63:0] fd [3];
        for (int i = 0; i < 3; i++) ch[i] = rand_chunk();
        fh[0] = 2'b10; fd[0] = 64'hD5555555_55555578;
        fh[1] = 2'b01; fd[1] = {$urandom, $urandom};
        fh[2] = 2'b10; fd[2] = 64'h00000000_000000FF;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, {$urandom, $urandom}, 1'b1, 1'b1, ch[i]);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(fh[i], fd[i], 1'b1, 1'b0, 64'h0);
            step();
            checks++;
            if (proced_encoded_tx_hdr !== fh[i] || proced_encoded_tx_data !== fd[i]) begin
                errors++;
                $display("FAIL frame_pass%0d got %h/%h want %h/%h", i, proced_encoded_tx_hdr,
                         proced_encoded_tx_data, fh[i], fd[i]);
            end
        end
        // An idle pattern that is flagged as frame traffic is also left alone
        drive(2'b10, 64'h1E, 1'b1, 1'b0, 64'h0);
        step();
        checks++;
        if (proced_encoded_tx_data !== 64'h1E) begin
            errors++;
            $display("FAIL netq_idle got %h want 1e", proced_encoded_tx_data);
        end
        for (int i = 0; i < 3; i++) begin
            drive_idle(1'b0, 64'h0);
            step();
            checks++;
            if (proced_encoded_tx_hdr !== 2'b10 ||
                proced_encoded_tx_data !== {ch[i][63:8], 8'h00}) begin
                errors++;
                $display("FAIL drain%0d got %h/%h want 2/%h", i, proced_encoded_tx_hdr,
                         proced_encoded_tx_data, {ch[i][63:8], 8'h00});
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(2'b01, {$urandom, $urandom}, 1'b1, 1'b1, rand_chunk());
            step();
            checks++;
            if (tx_pause !== (i >= 12) || memq_overflow !== (i >= 17)) begin
                errors++;
                $display("FAIL bp_write%0d got pause=%b ovf=%b want %b %b", i, tx_pause,
                         memq_overflow, (i >= 12), (i >= 17));
            end
        end
        // Exactly 16 chunks must drain in order; the 17th idle passes through
        for (int i = 0; i < 17; i++) begin
            drive_idle(1'b0, 64'h0);
            step();
            checks++;
            if (proced_encoded_tx_hdr !== exp_hdr || proced_encoded_tx_data !== exp_data ||
                tx_pause !== exp_pause || memq_overflow !== 1'b1) begin
                errors++;
                $display("FAIL bp_drain%0d got %h/%h p%b o%b want %h/%h p%b o1", i,
                         proced_encoded_tx_hdr, proced_encoded_tx_data, tx_pause,
                         memq_overflow, exp_hdr, exp_data, exp_pause);
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] first;
        logic [63:0] extra;
        apply_reset();
        first = rand_chunk();
        for (int i = 0; i < 16; i++) begin
            drive(2'b01, {$urandom, $urandom}, 1'b1, 1'b1, (i == 0) ? first : rand_chunk());
            step();
        end
        extra = rand_chunk();
        drive_idle(1'b1, extra);
        step();
        checks++;
        if (proced_encoded_tx_data !== {first[63:8], 8'h00} || memq_overflow !== 1'b0 ||
            tx_pause !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop got %h o%b p%b want %h o0 p1", proced_encoded_tx_data,
                     memq_overflow, tx_pause, {first[63:8], 8'h00});
        end
        // Count still 16: sixteen more injections, the last one being the extra chunk
        for (int i = 0; i < 17; i++) begin
            drive_idle(1'b0, 64'h0);
            step();
            checks++;
            if (proced_encoded_tx_data !== exp_data || memq_overflow !== 1'b0) begin
                errors++;
                $display("FAIL full_drain%0d got %h o%b want %h o0", i, proced_encoded_tx_data,
                         memq_overflow, exp_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] ch;
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 64'h77, 1'b1, 1'b1, rand_chunk());
            step();
        end
        drive_idle(1'b0, 64'h0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (proced_encoded_tx_hdr !== 2'b10 || proced_encoded_tx_data !== 64'h1E) begin
            errors++;
            $display("FAIL async_reset got %h/%h want 2/1e", proced_encoded_tx_hdr,
                     proced_encoded_tx_data);
        end
        apply_reset();
        drive_idle(1'b0, 64'h0);
        step();
        checks++;
        if (proced_encoded_tx_data !== 64'h1E || tx_pause !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got %h p%b want 1e p0", proced_encoded_tx_data,
                     tx_pause);
        end
        ch = rand_chunk();
        drive(2'b01, 64'h99, 1'b1, 1'b1, ch);
        step();
        drive_idle(1'b0, 64'h0);
        step();
        checks++;
        if (proced_encoded_tx_data !== {ch[63:8], 8'h00}) begin
            errors++;
            $display("FAIL reset_refill got %h want %h", proced_encoded_tx_data,
                     {ch[63:8], 8'h00});
        end
    endtask

    task automatic test_random();
        int unsigned sel;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(99, 0);
            // First half fills the FIFO, second half drains it
            if (sel < ((n < 300) ? 25 : 65)) begin
                drive(2'b10, 64'h1E, ($urandom_range(9, 0) == 0), 1'b0, 64'h0);
            end else if (sel < 80) begin
                drive(2'b01, {$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
            end else if (sel < 90) begin
                drive(2'b10, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
            end else if (sel < 95) begin
                drive(2'b10, {24'h0, $urandom_range(255, 1), 32'h1E}, 1'b0, 1'b0, 64'h0);
            end else begin
                drive(2'b01, 64'h1E, 1'b0, 1'b0, 64'h0);
            end
            memq_write      = ($urandom_range(99, 0) < ((n < 300) ? 60 : 20));
            ipg_reply_chunk = rand_chunk();
            step();
            checks++;
            if (proced_encoded_tx_hdr !== exp_hdr || proced_encoded_tx_data !== exp_data) begin
                errors++;
                $display("FAIL rand_block%0d got %h/%h want %h/%h", n, proced_encoded_tx_hdr,
                         proced_encoded_tx_data, exp_hdr, exp_data);
            end
            checks++;
            if (tx_pause !== exp_pause || memq_overflow !== exp_ovf) begin
                errors++;
                $display("FAIL rand_flags%0d got p%b o%b want p%b o%b", n, tx_pause,
                         memq_overflow, exp_pause, exp_ovf);
            end
`ifdef IPG_TX_STATS_EN
            checks++;
            if (ipg_insert_count !== m_inserts) begin
                errors++;
                $display("FAIL rand_stats%0d got %0d want %0d", n, ipg_insert_count, m_inserts);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle(1'b0, 64'h0);
        exp_hdr   = 2'b10;
        exp_data  = 64'h1E;
        exp_pause = 1'b0;
        exp_ovf   = 1'b0;
        test_reset();
        test_passthrough();
        test_injection();
        test_no_inject_frames();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipg_tx_inject.md
# ipg_tx_inject

Inter-packet-gap (IPG) message injector for the 10G BASE-R transmit path. It sits between the 64b/66b XGMII encoder and the TX gearbox/scrambler interface. It buffers 64-bit reply chunks from the memory side in a small FIFO and substitutes them, one per block, into idle control blocks of the encoded stream. Frame blocks pass through unchanged with a fixed one-cycle latency.

## Interface
Parameters:
- DATA_WIDTH, 64, encoded block payload width; only 64 is legal.
- HDR_WIDTH, 2, sync header width; only 2 is legal.
- FIFO_DEPTH, 16, reply-chunk FIFO depth; must be a power of two and at least 4.
- PAUSE_THRESH, 12, FIFO occupancy at or above which tx_pause asserts; range 1..FIFO_DEPTH.
- IPG_BLOCK_TYPE, 8'h00, block-type byte that marks an injected block; must not be a valid 802.3 type.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  asynchronous, active-low reset.
- encoded_tx_data  input  64  encoder block payload.
- encoded_tx_hdr  input  2  encoder sync header (2'b01 = data, 2'b10 = control).
- netq_write  input  1  from the encoder; 1 = current block belongs to a frame and must not be replaced.
- memq_write  input  1  push ipg_reply_chunk into the FIFO this cycle.
- ipg_reply_chunk  input  64  reply chunk; bits [63:8] are payload, bits [7:0] are reserved and senders drive 0.
- proced_encoded_tx_data  output  64  block payload toward the TX interface.
- proced_encoded_tx_hdr  output  2  sync header toward the TX interface.
- tx_pause  output  1  FIFO occupancy ≥ PAUSE_THRESH; the reply source must stop writing.
- memq_overflow  output  1  sticky; set when a write is dropped.

## Operation
- An idle block is defined by all of:
  - encoded_tx_hdr == 2'b10
  - encoded_tx_data[7:0] == 8'h1E
  - encoded_tx_data[63:8] == 0
- Injection condition: netq_write == 0, the input block is idle, and the FIFO is not empty.
  - When the condition holds, the block pops the FIFO head and outputs hdr 2'b10 with data {head[63:8], IPG_BLOCK_TYPE}.
  - Otherwise the input hdr and data pass through unchanged.
- Only idle blocks are ever replaced:
  - Blocks with netq_write == 1 always pass through unchanged.
  - Non-idle control blocks (start, terminate, ordered sets, error) always pass through unchanged.
- FIFO behaviour:
  - memq_write pushes when the FIFO is not full.
  - A push while full is dropped and sets memq_overflow.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full (the pop frees the slot) and when it is empty (write-through is not allowed; the new chunk is popped no earlier than the next cycle).
  - Chunks leave strictly in write order. Pointers wrap modulo FIFO_DEPTH.
  - Occupancy counter width is log2(FIFO_DEPTH)+1.
- tx_pause is combinational from the registered occupancy: 1 when count ≥ PAUSE_THRESH.
- memq_overflow clears only on reset.

## Timing
- Data path latency is exactly 1 cycle: the input block in cycle N appears on the outputs in cycle N+1, whether passed through or replaced.
- A chunk written in cycle N is eligible for injection from cycle N+1.
- Occupancy and tx_pause update in the cycle after a push or pop.
- Reset state (asserted asynchronously, released synchronously to clk):
  - proced_encoded_tx_hdr = 2'b10
  - proced_encoded_tx_data = 64'h000000000000001E
  - FIFO empty, tx_pause = 0, memq_overflow = 0
- Reset asserted mid-injection discards all FIFO contents. The first output after release is a pass-through of the current input block.

## Configuration
- Macro IPG_TX_STATS_EN.
  - Defined: adds output port ipg_insert_count [31:0]. It increments by 1 on each injected block, wraps at 2^32, and resets to 0.
  - Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset check: hold rst_n = 0 → outputs hdr 2'b10, data 64'h1E, tx_pause 0, memq_overflow 0.
- Pass-through, FIFO empty:
  - Stimulus: an idle stream, then a frame block with hdr 2'b01, data 64'hDEADBEEF_01234567, netq_write 1.
  - Required: identical outputs one cycle later.
- Injection:
  - Stimulus: write chunk 64'h1122334455667700, then present an idle block.
  - Required: next-cycle output is hdr 2'b10, data 64'h1122334455667700 (type byte 8'h00); the FIFO is empty afterward.
- No injection into frames:
  - Stimulus: FIFO holds 3 chunks; present start, data, and terminate blocks with netq_write 1.
  - Required: all pass unchanged; the chunks then drain in order into the next 3 idle blocks.
- Back-pressure and overflow:
  - Stimulus: 12 writes with no idles.
  - Required: tx_pause = 1 from the cycle after the 12th write.
  - Stimulus: continue to 17 writes.
  - Required: memq_overflow = 1 and count = 16.
- Simultaneous push and pop while full:
  - Stimulus: FIFO full; memq_write with an idle input block in the same cycle.
  - Required: count stays 16, no overflow, the oldest chunk is emitted.
